// File: rtl/analog_pad_sequencer_if.sv
// Wishbone slave bus bundle for analog_pad_sequencer.
// Signal names keep the Caravel wbs_* naming so the wrapper can connect them directly.
interface analog_pad_sequencer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/analog_pad_sequencer.sv
// Break-before-make sequencer for the analog-shared user pads [17:12], Wishbone programmed.
// Define ANALOG_PAD_SEQ_IRQ_EN to add the one-cycle irq completion pulse.
module analog_pad_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          NPADS      = 6,
  parameter int          SETTLE_W   = 8,
  parameter int          SETTLE_RST = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n,
  analog_pad_sequencer_if.slave wb,
  output logic [NPADS-1:0]     pad_out,
  output logic [NPADS-1:0]     pad_oeb,
  output logic                 busy
`ifdef ANALOG_PAD_SEQ_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_SETTLE,
    S_DRIVE,
    S_ENABLE
  } state_t;

  state_t              state_q, state_d;
  logic [NPADS-1:0]    tgt_out, tgt_oeb;
  logic [NPADS-1:0]    act_out, act_oeb;
  logic [SETTLE_W-1:0] settle_q, cnt_q;
  logic                pending_q, done_q, served_q;

  logic        req, acc, cfg_wr, settle_wr, status_wr;
  logic [5:0]  word;
  logic [31:0] settle_word, rd_data;
  logic        take, do_break, do_drive, do_enable, dec;

  // A request held across its ack is not re-acked; served_q stays set until the master drops it.
  assign req       = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc       = req & ~served_q;
  assign word      = wb.wbs_adr_i[7:2];
  assign cfg_wr    = acc & wb.wbs_we_i & (word == 6'd0);
  assign settle_wr = acc & wb.wbs_we_i & (word == 6'd1);
  assign status_wr = acc & wb.wbs_we_i & (word == 6'd2);
  assign busy      = (state_q != S_IDLE);

  logic unused_ok;
  assign unused_ok = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, settle_word};

  always_comb begin
    settle_word = 32'(settle_q);
    for (int b = 0; b < 4; b++)
      if (wb.wbs_sel_i[b]) settle_word[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
  end

  always_comb begin
    rd_data = '0;
    case (word)
      6'd0: begin
        rd_data[NPADS-1:0]   = tgt_out;
        rd_data[8 +: NPADS]  = tgt_oeb;
      end
      6'd1:    rd_data[SETTLE_W-1:0] = settle_q;
      6'd2:    rd_data[2:0] = {done_q, pending_q, busy};
      default: rd_data = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    do_break  = 1'b0;
    do_drive  = 1'b0;
    do_enable = 1'b0;
    dec       = 1'b0;
    case (state_q)
      S_IDLE: if (pending_q) begin
        take    = 1'b1;
        state_d = S_BREAK;
      end
      S_BREAK: begin
        do_break = 1'b1;
        state_d  = (cnt_q == '0) ? S_DRIVE : S_SETTLE;
      end
      S_SETTLE: begin
        dec = 1'b1;
        if (cnt_q == SETTLE_W'(1)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        do_drive = 1'b1;
        state_d  = S_ENABLE;
      end
      S_ENABLE: begin
        do_enable = 1'b1;
        if (pending_q) begin
          take    = 1'b1;
          state_d = S_BREAK;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state updates below use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      served_q     <= 1'b0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      tgt_out      <= '0;
      tgt_oeb      <= '1;
      act_out      <= '0;
      act_oeb      <= '1;
      settle_q     <= SETTLE_W'(SETTLE_RST);
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      pad_out      <= '0;
      pad_oeb      <= '1;
    end else begin
      served_q     <= req;
      wb.wbs_ack_o <= acc;
      wb.wbs_dat_o <= acc ? rd_data : '0;

      if (cfg_wr) begin
        if (wb.wbs_sel_i[0]) tgt_out <= wb.wbs_dat_i[NPADS-1:0];
        if (wb.wbs_sel_i[1]) tgt_oeb <= wb.wbs_dat_i[8 +: NPADS];
      end
      if (settle_wr) settle_q <= settle_word[SETTLE_W-1:0];

      // A CFG write landing on the same edge the FSM consumes pending queues a fresh sequence.
      if (cfg_wr)    pending_q <= 1'b1;
      else if (take) pending_q <= 1'b0;

      if (take) begin
        act_out <= tgt_out;
        act_oeb <= tgt_oeb;
        cnt_q   <= settle_q;
      end else if (dec) begin
        cnt_q   <= cnt_q - SETTLE_W'(1);
      end

      if (do_break)  pad_oeb <= '1;
      if (do_drive)  pad_out <= act_out;
      if (do_enable) pad_oeb <= act_oeb;

      if (do_enable)
        done_q <= 1'b1;
      else if (status_wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[2])
        done_q <= 1'b0;
    end
  end

`ifdef ANALOG_PAD_SEQ_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) irq <= 1'b0;
    else           irq <= do_enable;
  end
`endif

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// Directed self-checking bench for analog_pad_sequencer; edge numbers Ek count from the CFG write ack.
module tb_analog_pad_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  analog_pad_sequencer_if bus ();
  logic [5:0] pad_out, pad_oeb;
  logic       busy;

`ifdef ANALOG_PAD_SEQ_IRQ_EN
  logic irq;
  int   irq_cnt = 0;
  always @(negedge clk) if (irq) irq_cnt++;
`endif

  analog_pad_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wb       (bus),
    .pad_out  (pad_out),
    .pad_oeb  (pad_oeb),
    .busy     (busy)
`ifdef ANALOG_PAD_SEQ_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) ok = 1'b1;
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  // Returns one time unit after the ack edge (E0+1); starts with one idle cycle.
  task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic ok;
    step(1);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    wait_ack(ok);
    bus_idle();
    if (!ok) check({tag, "_ack"}, 32'(ok), 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr, output logic [31:0] dat);
    logic ok;
    step(1);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    wait_ack(ok);
    dat = bus.wbs_dat_o;
    bus_idle();
    check({tag, "_ack"}, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          acks;

    rst_n = 1'b0;
    bus_idle();
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1);

    // Reset state
    check("rst_oeb", 32'(pad_oeb), 32'h3F);
    check("rst_out", 32'(pad_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    wb_read("rd_settle", BASE + 32'h04, rd);
    check("rst_settle", rd, 32'h10);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("rst_status", rd, 32'h0);
    wb_read("rd_cfg", BASE + 32'h00, rd);
    check("rst_cfg", rd, 32'h3F00);

    // Byte selects: a write to SETTLE hitting only byte 1 leaves it unchanged
    wb_write("settle_sel", BASE + 32'h04, 32'h0000_7777, 4'b0010);
    wb_read("rd_settle", BASE + 32'h04, rd);
    check("settle_sel", rd, 32'h10);

    // SETTLE = 0: out at E3, oeb at E4
    wb_write("settle0", BASE + 32'h04, 32'h0, 4'hF);
    wb_write("cfg_a", BASE + 32'h00, 32'h0000_0A15, 4'hF);
    step(2);
    check("s0_out_e2", 32'(pad_out), 32'h00);
    check("s0_oeb_e2", 32'(pad_oeb), 32'h3F);
    step(1);
    check("s0_out_e3", 32'(pad_out), 32'h15);
    check("s0_oeb_e3", 32'(pad_oeb), 32'h3F);
    check("s0_busy_e3", 32'(busy), 32'd1);
    step(1);
    check("s0_oeb_e4", 32'(pad_oeb), 32'h0A);
    check("s0_busy_e4", 32'(busy), 32'd0);

    // SETTLE = 4, CFG = 0x152A: oeb 3F from E2, out 2A from E7, oeb 15 from E8
    wb_write("settle4", BASE + 32'h04, 32'h4, 4'hF);
    wb_write("clr_done", BASE + 32'h08, 32'h4, 4'hF);
`ifdef ANALOG_PAD_SEQ_IRQ_EN
    irq_cnt = 0;
`endif
    wb_write("cfg_b", BASE + 32'h00, 32'h0000_152A, 4'hF);
    step(1);
    check("s4_busy_e1", 32'(busy), 32'd1);
    check("s4_oeb_e1", 32'(pad_oeb), 32'h0A);
    step(1);
    check("s4_oeb_e2", 32'(pad_oeb), 32'h3F);
    step(4);
    check("s4_out_e6", 32'(pad_out), 32'h15);
    step(1);
    check("s4_out_e7", 32'(pad_out), 32'h2A);
    check("s4_oeb_e7", 32'(pad_oeb), 32'h3F);
    check("s4_busy_e7", 32'(busy), 32'd1);
    step(1);
    check("s4_oeb_e8", 32'(pad_oeb), 32'h15);
    check("s4_busy_e8", 32'(busy), 32'd0);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("s4_status", rd, 32'h4);
`ifdef ANALOG_PAD_SEQ_IRQ_EN
    step(2);
    check("s4_irq_cnt", 32'(irq_cnt), 32'd1);
`endif
    wb_write("clr_done", BASE + 32'h08, 32'h4, 4'hF);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("w1c_status", rd, 32'h0);

    // Two CFG writes during one sequence: latest wins, exactly one extra sequence
    wb_write("cfg_c", BASE + 32'h00, 32'h0000_0101, 4'hF);
    wb_write("cfg_d", BASE + 32'h00, 32'h0000_3F00, 4'hF);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("pend_status", rd, 32'h3);
    step(3);
    check("q_out_e7", 32'(pad_out), 32'h01);
    step(1);
    check("q_oeb_e8", 32'(pad_oeb), 32'h01);
    check("q_busy_e8", 32'(busy), 32'd1);
    step(1);
    check("q_oeb_e9", 32'(pad_oeb), 32'h3F);
    step(5);
    check("q_out_e14", 32'(pad_out), 32'h00);
    check("q_busy_e14", 32'(busy), 32'd1);
    step(1);
    check("q_oeb_e15", 32'(pad_oeb), 32'h3F);
    check("q_busy_e15", 32'(busy), 32'd0);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("q_status", rd, 32'h4);
    step(10);
    check("q_no_third", 32'(busy), 32'd0);

    // Reset asserted mid-SETTLE
    wb_write("settle0", BASE + 32'h04, 32'h0, 4'hF);
    wb_write("cfg_e", BASE + 32'h00, 32'h0000_0A15, 4'hF);
    step(4);
    check("pre_rst_out", 32'(pad_out), 32'h15);
    wb_write("settle4", BASE + 32'h04, 32'h4, 4'hF);
    wb_write("cfg_f", BASE + 32'h00, 32'h0000_2A3F, 4'hF);
    step(4);
    check("in_settle_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(pad_out), 32'h00);
    check("arst_oeb", 32'(pad_oeb), 32'h3F);
    check("arst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    step(20);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out", 32'(pad_out), 32'h00);
    check("post_rst_oeb", 32'(pad_oeb), 32'h3F);
    wb_read("rd_status", BASE + 32'h08, rd);
    check("post_rst_status", rd, 32'h0);
    wb_read("rd_cfg", BASE + 32'h00, rd);
    check("post_rst_cfg", rd, 32'h3F00);

    // Held strobe gets exactly one ack
    step(1);
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + 32'h04;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) acks++;
      if (i == 2) bus_idle();
    end
    check("hold_one_ack", 32'(acks), 32'd1);

    // Outside the window: no ack
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = BASE + 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("outside_no_ack", 32'(acks), 32'd0);

    // Unmapped offset inside the window: ack, read 0, write ignored
    wb_read("rd_0x40", BASE + 32'h40, rd);
    check("rd_0x40_data", rd, 32'h0);
    wb_write("wr_0x40", BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    step(8);
    check("wr_0x40_busy", 32'(busy), 32'd0);
    wb_read("rd_settle", BASE + 32'h04, rd);
    check("wr_0x40_settle", rd, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
